lsu: RTL
========

// Module: lsu
// PURPOSE
//  Load/store unit for the EX->MEM boundary of the RV32I core. Consumes the ALU result as the effective address.
//  Runs one data-memory transaction over a req/gnt/rvalid bus.
//  Returns a sign/zero-extended load value, or a store completion, to writeback.
//  Flags misaligned, illegal and timed-out accesses. Only one access is in flight at a time (non-pipelined).
// PARAMETERS
//  XLEN            32   data/address width
//  TIMEOUT_CYCLES  64   max cycles in REQ+WAIT before bus-timeout fault (>=2)
// PORTS
//  clk         in   1      core clock, rising edge
//  rst_n       in   1      async active-low reset
//  req_valid   in   1      EX presents a memory op
//  req_ready   out  1      LSU can accept (IDLE only)
//  req_we      in   1      1=store, 0=load
//  req_funct3  in   3      000 B, 001 H, 010 W, 100 BU, 101 HU
//  req_addr    in   XLEN   effective address (ALU result)
//  req_wdata   in   XLEN   store data (rs2)
//  req_rd      in   5      load destination register
//  mem_req     out  1      bus request, held until mem_gnt
//  mem_we      out  1      bus write enable
//  mem_be      out  4      byte enables
//  mem_addr    out  XLEN   word-aligned address ({req_addr[31:2],2'b00})
//  mem_wdata   out  XLEN   lane-replicated store data
//  mem_gnt     in   1      bus accepted request this cycle
//  mem_rvalid  in   1      read data valid
//  mem_rdata   in   XLEN   read data word
//  wb_valid    out  1      one-cycle completion pulse
//  wb_we       out  1      1 = write wb_data to wb_rd (loads without fault)
//  wb_rd       out  5      destination register
//  wb_data     out  XLEN   extended load value (0 for stores/faults)
//  wb_exc      out  2      0 none, 1 misaligned, 2 bus timeout, 3 illegal funct3
// BEHAVIOUR
//  Reset: state IDLE; req_ready=1, all other outputs 0; timeout counter 0. Reset mid-access drops mem_req immediately.
//   No wb_valid is generated for the aborted op.
//  FSM states IDLE, REQ, WAIT, DONE. All outputs are registered.
//  IDLE: req_ready=1. Accept on req_valid. Latch we/funct3/addr/wdata/rd.
//   - Illegal funct3 (011,110,111; or store with 1xx) -> DONE with exc=3.
//   - H with addr[0]!=0, or W with addr[1:0]!=0 -> DONE with exc=1. No bus access occurs.
//   - Otherwise -> REQ.
//  REQ: mem_req=1, with mem_we/mem_be/mem_addr/mem_wdata stable until gnt.
//   - On mem_gnt: mem_req drops next cycle. A store goes to DONE; a load goes to WAIT.
//  WAIT: on mem_rvalid, extract lane addr[1:0] and sign/zero-extend per funct3 -> DONE.
//   - rvalid in the same cycle as gnt is illegal for the bus and is ignored.
//  Timeout: counter increments every cycle in REQ or WAIT and clears on entry to REQ.
//   - On reaching TIMEOUT_CYCLES-1 without completion -> DONE with exc=2, mem_req dropped.
//  DONE: wb_valid=1 for exactly one cycle, then IDLE.
//   - wb_we=1 only for a load with exc=0. rd=x0 is still reported; regfile ignores x0.
//  Byte enables: B 4'b0001<<off, H 4'b0011<<off, W 4'b1111.
//  Store data replication: B {4{wdata[7:0]}}, H {2{wdata[15:0]}}, W wdata.
//  Latency (accept cycle = 0):
//   - Store with gnt in its first REQ cycle: wb_valid at cycle 2.
//   - Load with gnt at 1 and rvalid at 2: wb_valid at cycle 3.
//   - Fault detected at accept: wb_valid at cycle 1.
//  req_ready is low from the accept edge until the DONE->IDLE transition.
// STRUCTURE
//  riscv_pkg: FUNCT3_{LB,LH,LW,LBU,LHU,SB,SH,SW} constants; lsu_state_t enum; lsu_exc_t cause codes.
//  Sub-module lsu_data_align (combinational):
//   - store side: funct3, offset, wdata -> be, wdata_rep
//   - load side: funct3, offset, rdata -> extended value
//  The lsu top holds the FSM, the latches and the timeout counter.
// TESTING
//  1. SW addr 0x100, wdata 0xDEADBEEF, gnt same cycle
//     -> mem_be 1111, mem_addr 0x100; wb_valid at cycle 2, wb_we 0, exc 0.
//  2. LB addr 0x203, rdata 0x80AABBCC
//     -> wb_data 0xFFFFFF80. LBU at the same address -> 0x00000080. LHU addr 0x202 -> 0x000080AA.
//  3. SB addr 0x11, wdata 0x12345678 -> mem_be 0010, mem_wdata 0x78787878.
//  4. LW addr 0x102 -> no mem_req; wb_valid at cycle 1, exc 1.
//     funct3 011 -> exc 3.
//  5. Load with gnt delayed 3 cycles, then rvalid never asserted
//     -> exc 2 at TIMEOUT_CYCLES; req_ready returns high.
//  6. rst_n asserted low while in WAIT
//     -> mem_req 0 and req_ready 1 immediately, no wb_valid; the next op completes normally.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I load/store definitions: funct3 codes, LSU state and fault causes.
package riscv_pkg;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_REQ,
        LSU_WAIT,
        LSU_DONE
    } lsu_state_t;

    typedef enum logic [1:0] {
        EXC_NONE     = 2'd0,
        EXC_MISALIGN = 2'd1,
        EXC_TIMEOUT  = 2'd2,
        EXC_ILLEGAL  = 2'd3
    } lsu_exc_t;

    // Control fields of the accepted op, held for the whole access.
    typedef struct packed {
        logic       we;
        logic [2:0] funct3;
        logic [4:0] rd;
    } lsu_op_t;

    // Stores only exist as B/H/W; loads add the unsigned B/H forms.
    function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        if (we) ok = (f3 == FUNCT3_SB) || (f3 == FUNCT3_SH) || (f3 == FUNCT3_SW);
        else    ok = (f3 == FUNCT3_LB) || (f3 == FUNCT3_LH) || (f3 == FUNCT3_LW) ||
                     (f3 == FUNCT3_LBU) || (f3 == FUNCT3_LHU);
        return ok;
    endfunction

    // Halves need an even offset, words a zero offset; bytes never fault.
    function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic mis;
        case (f3[1:0])
            2'b01:   mis = off[0];
            2'b10:   mis = |off;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Lane steering: byte enables and replicated store data on the way out,
// lane extraction plus sign/zero extension on the way back.
module lsu_data_align
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      offset,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rdata,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wdata_rep,
    output logic [XLEN-1:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Select the addressed byte and half-word lanes of the returned word
    always_comb begin
        ld_byte = rdata[{offset, 3'b000} +: 8];
        ld_half = offset[1] ? rdata[31:16] : rdata[15:0];
    end

    // Size from funct3[1:0], signedness from funct3[2]
    always_comb begin
        be        = 4'b0000;
        wdata_rep = '0;
        ld_data   = '0;
        case (funct3[1:0])
            2'b00: begin
                be        = 4'b0001 << offset;
                wdata_rep = {(XLEN/8){wdata[7:0]}};
                ld_data   = funct3[2] ? XLEN'(ld_byte) : {{(XLEN-8){ld_byte[7]}}, ld_byte};
            end
            2'b01: begin
                be        = 4'b0011 << offset;
                wdata_rep = {(XLEN/16){wdata[15:0]}};
                ld_data   = funct3[2] ? XLEN'(ld_half) : {{(XLEN-16){ld_half[15]}}, ld_half};
            end
            default: begin
                be        = 4'b1111;
                wdata_rep = wdata;
                ld_data   = rdata;
            end
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Non-pipelined load/store unit: one bus transaction in flight, registered
// outputs, fault reporting for illegal, misaligned and timed-out accesses.
module lsu
    import riscv_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [4:0]      req_rd,
    output logic            mem_req,
    output logic            mem_we,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            wb_valid,
    output logic            wb_we,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic [1:0]      wb_exc
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_t      state_q, state_d;
    lsu_op_t         op_q, op_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    lsu_exc_t        exc_d;
    logic            timed_out;

    logic            req_ready_q, req_ready_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [3:0]      mem_be_q, mem_be_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
    logic            wb_valid_q, wb_valid_d;
    logic            wb_we_q, wb_we_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    lsu_exc_t        wb_exc_q, wb_exc_d;

    logic [3:0]      al_be;
    logic [XLEN-1:0] al_wdata;
    logic [XLEN-1:0] al_ld;

    // Fed from the next-cycle op so bus outputs are ready on the accept edge
    lsu_data_align #(.XLEN(XLEN)) u_align (
        .funct3    (op_d.funct3),
        .offset    (addr_d[1:0]),
        .wdata     (wdata_d),
        .rdata     (mem_rdata),
        .be        (al_be),
        .wdata_rep (al_wdata),
        .ld_data   (al_ld)
    );

    assign timed_out = (cnt_q == CNT_LAST);

    // Next state, op latches, timeout counter and fault cause
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        exc_d   = EXC_NONE;
        case (state_q)
            LSU_IDLE: begin
                if (req_valid) begin
                    op_d    = '{we: req_we, funct3: req_funct3, rd: req_rd};
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (!funct3_legal(req_we, req_funct3)) begin
                        state_d = LSU_DONE;
                        exc_d   = EXC_ILLEGAL;
                    end else if (addr_misaligned(req_funct3, req_addr[1:0])) begin
                        state_d = LSU_DONE;
                        exc_d   = EXC_MISALIGN;
                    end else begin
                        state_d = LSU_REQ;
                        cnt_d   = '0;
                    end
                end
            end
            LSU_REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A granted store is complete; a granted load still needs data,
                // so on the last allowed cycle only a store escapes the timeout.
                if (mem_gnt && op_q.we) begin
                    state_d = LSU_DONE;
                end else if (timed_out) begin
                    state_d = LSU_DONE;
                    exc_d   = EXC_TIMEOUT;
                end else if (mem_gnt) begin
                    state_d = LSU_WAIT;
                end
            end
            LSU_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (mem_rvalid) begin
                    state_d = LSU_DONE;
                end else if (timed_out) begin
                    state_d = LSU_DONE;
                    exc_d   = EXC_TIMEOUT;
                end
            end
            default: begin
                state_d = LSU_IDLE;
            end
        endcase
    end

    // Registered bus and writeback outputs derived from the next state
    always_comb begin
        req_ready_d = (state_d == LSU_IDLE);
        mem_req_d   = (state_d == LSU_REQ);
        mem_we_d    = mem_req_d & op_d.we;
        mem_be_d    = mem_req_d ? al_be : 4'b0000;
        mem_addr_d  = mem_req_d ? {addr_d[XLEN-1:2], 2'b00} : '0;
        mem_wdata_d = mem_we_d ? al_wdata : '0;
        wb_valid_d  = (state_d == LSU_DONE);
        wb_exc_d    = wb_valid_d ? exc_d : EXC_NONE;
        wb_we_d     = wb_valid_d & ~op_d.we & (exc_d == EXC_NONE);
        wb_rd_d     = wb_valid_d ? op_d.rd : 5'd0;
        wb_data_d   = wb_we_d ? al_ld : '0;
    end

    // State and output registers; reset abandons any access in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LSU_IDLE;
            op_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            req_ready_q <= 1'b1;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'b0000;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            wb_valid_q  <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_rd_q     <= 5'd0;
            wb_data_q   <= '0;
            wb_exc_q    <= EXC_NONE;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            wb_valid_q  <= wb_valid_d;
            wb_we_q     <= wb_we_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            wb_exc_q    <= wb_exc_d;
        end
    end

    assign req_ready = req_ready_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign wb_valid  = wb_valid_q;
    assign wb_we     = wb_we_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign wb_exc    = wb_exc_q;

endmodule
